bp_io_cmd_arbiter: RTL and testbench
====================================

Name: bp_io_cmd_arbiter

Overview:
- Shares the single BlackParrot I/O command channel between two requesters: the CCE config loader (cfg) and the manycore-side request forwarder (mc).
- Tracks outstanding commands in issue order, so each io_resp is steered back to the requester that issued the matching command.
- Sits between the config loader / manycore endpoint glue and the BP io_cmd_o / io_resp_i ports of the host bridge.

Parameters:
- msg_width_p, "inv", width of a bp_cce_mem_msg_s (cce_mem_msg_width_lp).
- max_outstanding_p, 4, maximum commands in flight awaiting response; depth of the source-tag FIFO (power of 2, >=2).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- cfg_done_i  in  1  config loader done; while low, mc requests are never granted
- cfg_cmd_i  in  msg_width_p  cfg command
- cfg_cmd_v_i  in  1  cfg command valid
- cfg_cmd_yumi_o  out  1  cfg command consumed
- mc_cmd_i  in  msg_width_p  mc command
- mc_cmd_v_i  in  1  mc command valid
- mc_cmd_yumi_o  out  1  mc command consumed
- io_cmd_o  out  msg_width_p  arbitrated command
- io_cmd_v_o  out  1  arbitrated command valid
- io_cmd_yumi_i  in  1  downstream consumed io_cmd_o
- io_resp_i  in  msg_width_p  response from BP
- io_resp_v_i  in  1  response valid
- io_resp_ready_o  out  1  response accepted when high with io_resp_v_i
- cfg_resp_o  out  msg_width_p  response to cfg
- cfg_resp_v_o  out  1  cfg response valid
- cfg_resp_ready_i  in  1  cfg ready
- mc_resp_o  out  msg_width_p  response to mc
- mc_resp_v_o  out  1  mc response valid
- mc_resp_ready_i  in  1  mc ready
- outstanding_o  out  clog2(max_outstanding_p+1)  commands in flight
- error_o  out  1  sticky: response arrived with no outstanding command

Behaviour:
- Reset (async, immediate): lock_r=0, grant_r=cfg, last_r=mc (cfg wins first tie), tag FIFO empty, outstanding_o=0, error_o=0. All valids and yumis are 0 while reset_i is high.
- Eligibility: cfg eligible = cfg_cmd_v_i. mc eligible = mc_cmd_v_i & cfg_done_i.
- Issue is allowed only when outstanding_o < max_outstanding_p. A response retiring in the same cycle does not free a slot for that cycle.
- States: IDLE (lock_r=0) and LOCKED (lock_r=1).
  - IDLE, issue allowed: pick a source. If one source is eligible, pick it. If both are eligible, pick round-robin, the one not equal to last_r.
  - io_cmd_v_o=1 combinationally, io_cmd_o = selected source's command.
  - If io_cmd_yumi_i is not high the same cycle, latch grant_r and go to LOCKED.
  - LOCKED: io_cmd_v_o=1 and io_cmd_o follow grant_r only. The grant must not change until yumi.
  - Requesters must hold valid and data until their yumi; dropping valid while LOCKED is a protocol violation (assertion).
- On io_cmd_yumi_i:
  - Assert the granted source's *_cmd_yumi_o the same cycle.
  - Push the source tag (0=cfg, 1=mc) into the FIFO, set last_r to that source, return to IDLE.
  - Zero added latency: IDLE to accept in one cycle is legal.
- Response path, in order:
  - Destination = tag at FIFO head.
  - dest_resp_v_o = io_resp_v_i & FIFO nonempty & head==dest. The other resp_v is 0.
  - *_resp_o = io_resp_i for both destinations (data unqualified).
  - io_resp_ready_o = FIFO nonempty & the head destination's ready.
  - Handshake (io_resp_v_i & io_resp_ready_o) pops the FIFO.
- Response with empty FIFO: io_resp_ready_o=1 (drain it), no resp_v to either destination, error_o set sticky until reset.
- outstanding_o = pushes minus pops. A simultaneous push and pop leaves it unchanged. Never exceeds max_outstanding_p, never underflows.
- cfg_done_i falling while mc is LOCKED: the lock is held until yumi. Only new grants are blocked.
- Reset mid-operation discards in-flight tags. Responses for them afterwards set error_o.

Test Plan:
- cfg_done_i=0, both cmd_v=1, io_cmd_yumi_i=1 every cycle -> 3 consecutive cfg grants, mc_cmd_yumi_o stays 0, outstanding_o=3.
- cfg_done_i=1, both valid continuously, yumi always 1, responses returned each cycle -> grants alternate cfg,mc,cfg,mc. Responses route cfg_resp_v_o, mc_resp_v_o alternately. outstanding_o never exceeds 1.
- Grant to mc, hold io_cmd_yumi_i=0 for 5 cycles while cfg also valid -> io_cmd_o stays mc data all 5 cycles. On the yumi cycle, mc_cmd_yumi_o=1 for exactly 1 cycle.
- max_outstanding_p=4, no responses, 6 cfg commands -> 4 accepted, then io_cmd_v_o=0 with outstanding_o=4. Deliver 1 response -> next cycle a 5th command issues.
- Head tag=mc, mc_resp_ready_i=0 for 3 cycles -> io_resp_ready_o=0, FIFO holds, cfg_resp_v_o=0. Then mc ready=1 -> pop, outstanding_o decrements by 1.
- Inject io_resp_v_i with outstanding_o=0 -> io_resp_ready_o=1, no resp_v asserted, error_o=1 until reset_i pulse clears it asynchronously.

Source files
------------

// File: rtl/bp_io_cmd_arbiter.sv
// Two-requester arbiter for the BlackParrot I/O command channel. A source-tag FIFO
// records the issue order so each io_resp returns to the requester that sent the command.
module bp_io_cmd_arbiter #(
  parameter int unsigned msg_width_p       = 32,
  parameter int unsigned max_outstanding_p = 4,
  localparam int unsigned CntW             = $clog2(max_outstanding_p + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   cfg_done_i,
  input  logic [msg_width_p-1:0] cfg_cmd_i,
  input  logic                   cfg_cmd_v_i,
  output logic                   cfg_cmd_yumi_o,
  input  logic [msg_width_p-1:0] mc_cmd_i,
  input  logic                   mc_cmd_v_i,
  output logic                   mc_cmd_yumi_o,
  output logic [msg_width_p-1:0] io_cmd_o,
  output logic                   io_cmd_v_o,
  input  logic                   io_cmd_yumi_i,
  input  logic [msg_width_p-1:0] io_resp_i,
  input  logic                   io_resp_v_i,
  output logic                   io_resp_ready_o,
  output logic [msg_width_p-1:0] cfg_resp_o,
  output logic                   cfg_resp_v_o,
  input  logic                   cfg_resp_ready_i,
  output logic [msg_width_p-1:0] mc_resp_o,
  output logic                   mc_resp_v_o,
  input  logic                   mc_resp_ready_i,
  output logic [CntW-1:0]        outstanding_o,
  output logic                   error_o
);

  localparam int unsigned PtrW = $clog2(max_outstanding_p);
  localparam logic [CntW-1:0] MaxCnt = CntW'(max_outstanding_p);

  typedef enum logic {StIdle, StLocked} state_e;

  // Source tags: 0 = cfg, 1 = mc
  state_e                       state_q;
  logic                         grant_q;
  logic                         last_q;
  logic [max_outstanding_p-1:0] tags_q;
  logic [PtrW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]              cnt_q;
  logic                         error_q;

  logic cfg_elig, mc_elig, issue_ok, sel, src, cmd_v, push, pop, empty, head;

  always_comb begin
    cfg_elig = cfg_cmd_v_i;
    mc_elig  = mc_cmd_v_i & cfg_done_i;
    issue_ok = (cnt_q < MaxCnt);
    // On a tie, favour whichever source did not win last
    sel      = (cfg_elig & mc_elig) ? ~last_q : mc_elig;
    src      = (state_q == StLocked) ? grant_q : sel;
    cmd_v    = ~reset_i & ((state_q == StLocked) | (issue_ok & (cfg_elig | mc_elig)));
    push     = cmd_v & io_cmd_yumi_i;
    empty    = (cnt_q == '0);
    head     = tags_q[rd_ptr_q];
    // An unexpected response is drained rather than stalling the channel
    io_resp_ready_o = empty | (head ? mc_resp_ready_i : cfg_resp_ready_i);
    pop      = io_resp_v_i & io_resp_ready_o & ~empty;
  end

  assign io_cmd_o       = src ? mc_cmd_i : cfg_cmd_i;
  assign io_cmd_v_o     = cmd_v;
  assign cfg_cmd_yumi_o = push & ~src;
  assign mc_cmd_yumi_o  = push & src;
  assign cfg_resp_o     = io_resp_i;
  assign mc_resp_o      = io_resp_i;
  assign cfg_resp_v_o   = ~reset_i & io_resp_v_i & ~empty & ~head;
  assign mc_resp_v_o    = ~reset_i & io_resp_v_i & ~empty & head;
  assign outstanding_o  = cnt_q;
  assign error_o        = error_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cmd_v && !io_cmd_yumi_i) begin
            state_q <= StLocked;
            grant_q <= sel;
          end
        end
        StLocked: begin
          if (io_cmd_yumi_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      if (push) begin
        tags_q[wr_ptr_q] <= src;
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
        last_q           <= src;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (io_resp_v_i && empty) error_q <= 1'b1;
    end
  end

  // A locked requester must keep its command valid until it is consumed
  a_hold_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    (state_q == StLocked) |-> (grant_q ? mc_cmd_v_i : cfg_cmd_v_i));

endmodule

// File: tb/tb_bp_io_cmd_arbiter.sv
// Directed self-checking bench for bp_io_cmd_arbiter with hand-computed expectations.
module tb_bp_io_cmd_arbiter;
  localparam int unsigned W = 8;
  localparam logic [W-1:0] CFG = 8'hC5, MC = 8'hA3, RSP = 8'h5E;

  logic clk_i = 1'b0;
  logic reset_i;
  logic cfg_done_i, cfg_cmd_v_i, cfg_cmd_yumi_o, mc_cmd_v_i, mc_cmd_yumi_o;
  logic [W-1:0] cfg_cmd_i, mc_cmd_i, io_cmd_o, io_resp_i, cfg_resp_o, mc_resp_o;
  logic io_cmd_v_o, io_cmd_yumi_i, io_resp_v_i, io_resp_ready_o;
  logic cfg_resp_v_o, cfg_resp_ready_i, mc_resp_v_o, mc_resp_ready_i, error_o;
  logic [2:0] outstanding_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  bp_io_cmd_arbiter #(.msg_width_p(W), .max_outstanding_p(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .cfg_done_i(cfg_done_i),
    .cfg_cmd_i(cfg_cmd_i), .cfg_cmd_v_i(cfg_cmd_v_i), .cfg_cmd_yumi_o(cfg_cmd_yumi_o),
    .mc_cmd_i(mc_cmd_i), .mc_cmd_v_i(mc_cmd_v_i), .mc_cmd_yumi_o(mc_cmd_yumi_o),
    .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_yumi_i(io_cmd_yumi_i),
    .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_ready_o(io_resp_ready_o),
    .cfg_resp_o(cfg_resp_o), .cfg_resp_v_o(cfg_resp_v_o),
    .cfg_resp_ready_i(cfg_resp_ready_i),
    .mc_resp_o(mc_resp_o), .mc_resp_v_o(mc_resp_v_o), .mc_resp_ready_i(mc_resp_ready_i),
    .outstanding_o(outstanding_o), .error_o(error_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_cmd_v_i = 0; mc_cmd_v_i = 0; io_cmd_yumi_i = 0; io_resp_v_i = 0;
    cfg_resp_ready_i = 0; mc_resp_ready_i = 0;
  endtask

  task automatic reset_pulse();
    idle_inputs();
    reset_i = 1;
    #2;
    reset_i = 0;
    #1;
  endtask

  initial begin
    cfg_cmd_i = CFG; mc_cmd_i = MC; io_resp_i = RSP; cfg_done_i = 0;
    idle_inputs();
    reset_i = 1;
    cfg_cmd_v_i = 1; io_cmd_yumi_i = 1; io_resp_v_i = 1;
    #1;
    chk("rst_cmd_v", io_cmd_v_o, 0);
    chk("rst_cfg_yumi", cfg_cmd_yumi_o, 0);
    chk("rst_resp_v", cfg_resp_v_o | mc_resp_v_o, 0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_error", error_o, 0);
    tick();
    idle_inputs();
    reset_i = 0;
    tick();

    // cfg_done low: mc never granted
    cfg_done_i = 0; cfg_cmd_v_i = 1; mc_cmd_v_i = 1; io_cmd_yumi_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("nodone_cmd", io_cmd_o, CFG);
      chk("nodone_cfg_yumi", cfg_cmd_yumi_o, 1);
      chk("nodone_mc_yumi", mc_cmd_yumi_o, 0);
      tick();
    end
    cfg_cmd_v_i = 0; mc_cmd_v_i = 0; io_cmd_yumi_i = 0;
    #1;
    chk("nodone_outstanding", outstanding_o, 3);
    io_resp_v_i = 1; cfg_resp_ready_i = 1; mc_resp_ready_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("drain_cfg_resp_v", cfg_resp_v_o, 1);
      chk("drain_mc_resp_v", mc_resp_v_o, 0);
      chk("drain_ready", io_resp_ready_o, 1);
      tick();
    end
    io_resp_v_i = 0;
    chk("drain_outstanding", outstanding_o, 0);
    chk("drain_error", error_o, 0);

    // Round robin with responses returned every cycle
    reset_pulse();
    cfg_done_i = 1; cfg_cmd_v_i = 1; mc_cmd_v_i = 1; io_cmd_yumi_i = 1;
    cfg_resp_ready_i = 1; mc_resp_ready_i = 1;
    for (int k = 0; k < 5; k++) begin
      io_resp_v_i = (k >= 1);
      if (k == 4) begin
        cfg_cmd_v_i = 0; mc_cmd_v_i = 0; io_cmd_yumi_i = 0;
      end
      #1;
      if (k < 4) begin
        chk("rr_cmd", io_cmd_o, (k % 2 == 0) ? CFG : MC);
        chk("rr_cfg_yumi", cfg_cmd_yumi_o, (k % 2 == 0));
        chk("rr_mc_yumi", mc_cmd_yumi_o, (k % 2 == 1));
      end
      chk("rr_cfg_resp_v", cfg_resp_v_o, (k % 2 == 1));
      chk("rr_mc_resp_v", mc_resp_v_o, (k >= 2) && (k % 2 == 0));
      chk("rr_outstanding", outstanding_o, (k == 0) ? 0 : 1);
      tick();
    end
    io_resp_v_i = 0;
    chk("rr_final_outstanding", outstanding_o, 0);
    chk("rr_error", error_o, 0);

    // Lock on mc, hold through cfg competition and cfg_done falling
    reset_pulse();
    cfg_done_i = 1; mc_cmd_v_i = 1;
    #1;
    chk("lock_first_cmd", io_cmd_o, MC);
    chk("lock_first_v", io_cmd_v_o, 1);
    tick();
    cfg_cmd_v_i = 1;
    for (int i = 1; i <= 5; i++) begin
      cfg_done_i = (i < 3);
      #1;
      chk("lock_cmd", io_cmd_o, MC);
      chk("lock_v", io_cmd_v_o, 1);
      chk("lock_yumis", {cfg_cmd_yumi_o, mc_cmd_yumi_o}, 2'b00);
      tick();
    end
    io_cmd_yumi_i = 1;
    #1;
    chk("lock_yumi_cmd", io_cmd_o, MC);
    chk("lock_yumi", {cfg_cmd_yumi_o, mc_cmd_yumi_o}, 2'b01);
    tick();
    io_cmd_yumi_i = 0; cfg_done_i = 1;
    #1;
    chk("unlock_mc_yumi", mc_cmd_yumi_o, 0);
    chk("unlock_next_cmd", io_cmd_o, CFG);
    chk("unlock_outstanding", outstanding_o, 1);
    tick();

    // Outstanding limit: a same-cycle retire does not free a slot
    reset_pulse();
    cfg_done_i = 1; cfg_cmd_v_i = 1; io_cmd_yumi_i = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("full_cmd_v", io_cmd_v_o, (i < 4));
      chk("full_cfg_yumi", cfg_cmd_yumi_o, (i < 4));
      tick();
    end
    chk("full_outstanding", outstanding_o, 4);
    io_resp_v_i = 1; cfg_resp_ready_i = 1;
    #1;
    chk("full_retire_cmd_v", io_cmd_v_o, 0);
    chk("full_retire_resp_v", cfg_resp_v_o, 1);
    tick();
    io_resp_v_i = 0;
    #1;
    chk("full_after_cmd_v", io_cmd_v_o, 1);
    chk("full_after_yumi", cfg_cmd_yumi_o, 1);
    chk("full_after_outstanding", outstanding_o, 3);
    tick();
    chk("full_refill", outstanding_o, 4);

    // Head tag mc stalls the response path until mc is ready
    reset_pulse();
    cfg_done_i = 1; mc_cmd_v_i = 1; io_cmd_yumi_i = 1;
    #1;
    chk("stall_issue_mc", mc_cmd_yumi_o, 1);
    tick();
    mc_cmd_v_i = 0; cfg_cmd_v_i = 1;
    #1;
    chk("stall_issue_cfg", cfg_cmd_yumi_o, 1);
    tick();
    cfg_cmd_v_i = 0; io_cmd_yumi_i = 0;
    io_resp_v_i = 1; cfg_resp_ready_i = 1; mc_resp_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", io_resp_ready_o, 0);
      chk("stall_cfg_resp_v", cfg_resp_v_o, 0);
      chk("stall_outstanding", outstanding_o, 2);
      tick();
    end
    mc_resp_ready_i = 1;
    #1;
    chk("stall_release_ready", io_resp_ready_o, 1);
    chk("stall_release_mc_v", mc_resp_v_o, 1);
    chk("stall_release_data", mc_resp_o, RSP);
    tick();
    mc_resp_ready_i = 0;
    #1;
    chk("stall_pop_outstanding", outstanding_o, 1);
    chk("stall_next_cfg_v", cfg_resp_v_o, 1);
    chk("stall_next_data", cfg_resp_o, RSP);

    // Reset discards the remaining tag; a stray response sets error
    reset_pulse();
    io_resp_v_i = 1;
    #1;
    chk("err_ready", io_resp_ready_o, 1);
    chk("err_resp_v", {cfg_resp_v_o, mc_resp_v_o}, 2'b00);
    chk("err_before", error_o, 0);
    tick();
    io_resp_v_i = 0;
    chk("err_set", error_o, 1);
    tick();
    tick();
    chk("err_sticky", error_o, 1);
    chk("err_outstanding", outstanding_o, 0);
    reset_i = 1;
    #1;
    chk("err_async_clear", error_o, 0);
    reset_i = 0;
    tick();
    chk("err_stays_clear", error_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
